// File: rtl/fuzzy_seq_engine.sv
// ============================================================================
// Module      : fuzzy_seq_engine
// Description : Time-multiplexed min-rule fuzzy evaluator with a writable
//               singleton table and a serial restoring-division defuzzifier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fuzzy_seq_engine #(
    parameter  int N_T       = 3,
    parameter  int N_D       = 3,
    parameter  int MU_W      = 16,
    parameter  int G_W       = 8,
    parameter  int DEFAULT_G = 50,
    localparam int NR        = N_T * N_D,
    localparam int AW        = (NR > 1) ? $clog2(NR) : 1,
    localparam int SW_W      = MU_W + AW,
    localparam int SWG_W     = MU_W + G_W + AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_T*MU_W-1:0] mu_t,
    input  logic [N_D*MU_W-1:0] mu_d,
    input  logic [NR-1:0]       rule_en,
    input  logic                g_we,
    input  logic [AW-1:0]       g_waddr,
    input  logic [G_W-1:0]      g_wdata,
    output logic                cfg_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [G_W-1:0]      g_out,
    output logic                zero_w
);

    localparam int DCW = $clog2(G_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [N_T*MU_W-1:0] mu_t_q, mu_t_d;
    logic [N_D*MU_W-1:0] mu_d_q, mu_d_d;
    logic [NR-1:0]       en_q, en_d;
    logic [G_W-1:0]      g_tab_q [NR];
    logic [AW-1:0]       i_q, i_d, r_q, r_d, c_q, c_d;
    logic [SW_W-1:0]     sw_q, sw_d;
    logic [SWG_W-1:0]    swg_q, swg_d;
    logic [SWG_W-1:0]    rem_q, rem_d;
    logic [SWG_W-1:0]    div_q, div_d;
    logic [G_W-1:0]      quo_q, quo_d;
    logic [DCW-1:0]      dcnt_q, dcnt_d;
    logic [G_W-1:0]      g_out_q, g_out_d;
    logic                zero_w_q, zero_w_d;
    logic                cfg_err_q;

    logic                w_accept;
    logic                w_addr_ok;
    logic                w_wr_ok;
    logic [MU_W-1:0]     w_mt, w_md, w_min;
    logic [SWG_W-1:0]    w_prod;

    assign w_accept  = (state_q == S_IDLE) && in_valid;
    assign w_addr_ok = (32'(g_waddr) < NR);
    assign w_wr_ok   = g_we && (state_q == S_IDLE) && w_addr_ok;

    assign w_mt   = mu_t_q[r_q*MU_W +: MU_W];
    assign w_md   = mu_d_q[c_q*MU_W +: MU_W];
    assign w_min  = (w_mt < w_md) ? w_mt : w_md;
    assign w_prod = SWG_W'(w_min) * SWG_W'(g_tab_q[i_q]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_ACC;
            S_ACC:  if (i_q == AW'(NR - 1)) state_d = S_DIV;
            S_DIV:  if (dcnt_q == DCW'(G_W)) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        g_out     = g_out_q;
        zero_w    = zero_w_q;
        cfg_err   = cfg_err_q;
    end

    // Datapath next-state
    always_comb begin
        mu_t_d   = mu_t_q;
        mu_d_d   = mu_d_q;
        en_d     = en_q;
        i_d      = i_q;
        r_d      = r_q;
        c_d      = c_q;
        sw_d     = sw_q;
        swg_d    = swg_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        dcnt_d   = dcnt_q;
        g_out_d  = g_out_q;
        zero_w_d = zero_w_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    mu_t_d = mu_t;
                    mu_d_d = mu_d;
                    en_d   = rule_en;
                    sw_d   = '0;
                    swg_d  = '0;
                    i_d    = '0;
                    r_d    = '0;
                    c_d    = '0;
                end
            end
            S_ACC: begin
                if (en_q[i_q]) begin
                    sw_d  = sw_q + SW_W'(w_min);
                    swg_d = swg_q + w_prod;
                end
                i_d = i_q + 1'b1;
                if (c_q == AW'(N_D - 1)) begin
                    c_d = '0;
                    r_d = r_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
                // Prime the divider from the final sums on the last rule.
                if (i_q == AW'(NR - 1)) begin
                    rem_d  = swg_d;
                    div_d  = SWG_W'(sw_d) << (G_W - 1);
                    quo_d  = '0;
                    dcnt_d = '0;
                end
            end
            S_DIV: begin
                if (dcnt_q != DCW'(G_W)) begin
                    if (rem_q >= div_q) begin
                        rem_d = rem_q - div_q;
                        quo_d = (quo_q << 1) | G_W'(1);
                    end else begin
                        quo_d = quo_q << 1;
                    end
                    div_d  = div_q >> 1;
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    zero_w_d = (sw_q == '0);
                    g_out_d  = (sw_q == '0) ? G_W'(DEFAULT_G) : quo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mu_t_q    <= '0;
            mu_d_q    <= '0;
            en_q      <= '0;
            i_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            sw_q      <= '0;
            swg_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            dcnt_q    <= '0;
            g_out_q   <= '0;
            zero_w_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            mu_t_q    <= mu_t_d;
            mu_d_q    <= mu_d_d;
            en_q      <= en_d;
            i_q       <= i_d;
            r_q       <= r_d;
            c_q       <= c_d;
            sw_q      <= sw_d;
            swg_q     <= swg_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            quo_q     <= quo_d;
            dcnt_q    <= dcnt_d;
            g_out_q   <= g_out_d;
            zero_w_q  <= zero_w_d;
            cfg_err_q <= g_we && !w_wr_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NR; k++) g_tab_q[k] <= '0;
        end else if (w_wr_ok) begin
            g_tab_q[g_waddr] <= g_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fuzzy_seq_engine.sv
// ============================================================================
// Module      : tb_fuzzy_seq_engine
// Description : Scoreboard bench for fuzzy_seq_engine with directed vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fuzzy_seq_engine;

    localparam int LAT = 18;

    typedef struct {
        logic [7:0] g;
        logic       z;
        int         acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] mu_t = '0;
    logic [47:0] mu_d = '0;
    logic [8:0]  rule_en = '0;
    logic        g_we = 1'b0;
    logic [3:0]  g_waddr = '0;
    logic [7:0]  g_wdata = '0;
    logic        cfg_err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  g_out;
    logic        zero_w;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    fuzzy_seq_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mu_t(mu_t), .mu_d(mu_d), .rule_en(rule_en),
        .g_we(g_we), .g_waddr(g_waddr), .g_wdata(g_wdata), .cfg_err(cfg_err),
        .out_valid(out_valid), .out_ready(out_ready), .g_out(g_out), .zero_w(zero_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: latency on rise, stability while stalled, value on handshake
    logic       prev_v = 1'b0;
    logic [7:0] held_g = '0;
    logic       held_z = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                held_g <= g_out;
                held_z <= zero_w;
                if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
                else check("latency", cyc - sb[0].acc, LAT);
            end else if (out_valid) begin
                check("hold_g_out", int'(g_out), int'(held_g));
                check("hold_zero_w", int'(zero_w), int'(held_z));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                check("g_out", int'(g_out), int'(sb[0].g));
                check("zero_w", int'(zero_w), int'(sb[0].z));
                void'(sb.pop_front());
            end
            prev_v <= out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        g_we = 1'b1; g_waddr = 4'(a); g_wdata = 8'(d);
        tick();
        g_we = 1'b0;
    endtask

    task automatic req(input logic [47:0] mt, input logic [47:0] md, input logic [8:0] en,
                       input int eg, input int ez, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check("in_ready_before_req", int'(in_ready), 1);
        mu_t = mt; mu_d = md; rule_en = en; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (push) sb.push_back('{g: 8'(eg), z: ez[0], acc: cyc});
        // Scramble inputs after the accept; the result must not follow them.
        mu_t = '1; mu_d = 48'h1234_5678_9ABC; rule_en = '1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin tick(); n++; end
        check("result_timeout", sb.size(), 0);
        sb.delete();
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_g_out", int'(g_out), 0);
        check("rst_zero_w", int'(zero_w), 0);
        check("rst_cfg_err", int'(cfg_err), 0);

        wr(0, 100); wr(1, 50); wr(2, 30); wr(3, 50); wr(4, 50);
        wr(5, 50);  wr(6, 80); wr(7, 50); wr(8, 0);
        check("cfg_err_idle_write", int'(cfg_err), 0);
        wr(9, 77);
        check("cfg_err_bad_addr", int'(cfg_err), 1);
        tick();
        check("cfg_err_one_cycle", int'(cfg_err), 0);

        req({16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 100, 0, 1); wait_done();
        req({16'h0, 16'h8000, 16'h8000}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 75, 0, 1); wait_done();
        req({16'h0, 16'h8000, 16'h8000}, {16'h0, 16'h0, 16'hFFFF}, 9'h001, 100, 0, 1); wait_done();
        req({16'h0, 16'h8000, 16'h8000}, {16'h0, 16'h0, 16'hFFFF}, 9'h000, 50, 1, 1); wait_done();
        req(48'h0, 48'h0, 9'h1FF, 50, 1, 1); wait_done();

        // Stalled consumer, ignored requests, dropped write during ACC
        out_ready = 1'b0;
        req({16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 100, 0, 1);
        tick();
        wr(0, 7);
        check("cfg_err_acc_write", int'(cfg_err), 1);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("out_valid_seen", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            check("in_ready_done", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();
        req({16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 100, 0, 1); wait_done();

        // Write and accept on the same edge
        g_we = 1'b1; g_waddr = 4'd0; g_wdata = 8'd200;
        req({16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 200, 0, 1);
        g_we = 1'b0;
        wait_done();

        // Reset during ACC discards the result and clears the table
        req({16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 0, 0, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        repeat (25) tick();
        check("midrst_no_result", int'(out_valid), 0);
        req({16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'hFFFF}, 9'h1FF, 0, 0, 1); wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
